// File: rtl/latency_scoreboard.sv
// Variable-latency transaction delay buffer: each accepted header/payload pair is held
// for MIN_LATENCY plus an LFSR-chosen extra number of cycles, then becomes poppable.
module latency_scoreboard #(
    parameter int NUM_TRANSACTIONS = 4,
    parameter int HDR_WIDTH        = 72,
    parameter int DATA_WIDTH       = 72,
    parameter int MIN_LATENCY      = 8,
    parameter int LAT_RANGE_BITS   = 3,
    parameter int COUNT_WIDTH      = $clog2(NUM_TRANSACTIONS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [HDR_WIDTH-1:0]   meta_in,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   valid_in,
    output logic [HDR_WIDTH-1:0]   meta_out,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   valid_out,
    input  logic                   read_en,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow,
    output logic                   underflow,
    output logic [COUNT_WIDTH-1:0] count
);

    localparam int          LAT_W     = LAT_RANGE_BITS + $clog2(MIN_LATENCY) + 1;
    localparam int          IDX_W     = $clog2(NUM_TRANSACTIONS);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    logic [NUM_TRANSACTIONS-1:0] slot_valid;
    logic [HDR_WIDTH-1:0]        slot_meta [NUM_TRANSACTIONS];
    logic [DATA_WIDTH-1:0]       slot_data [NUM_TRANSACTIONS];
    logic [LAT_W-1:0]            slot_lat  [NUM_TRANSACTIONS];
    logic [15:0]                 lfsr;

    logic [15:0]                 lfsr_nxt;
    logic [NUM_TRANSACTIONS-1:0] slot_ready;
    logic                        free_found;
    logic                        ready_found;
    logic [IDX_W-1:0]            wr_idx;
    logic [IDX_W-1:0]            rd_idx;
    logic                        wr_accept;
    logic                        rd_accept;
    logic [LAT_W-1:0]            load_lat;
    logic [COUNT_WIDTH-1:0]      count_nxt;

    always_comb begin
        lfsr_nxt = {1'b0, lfsr[15:1]};
        if (lfsr[0]) begin
            lfsr_nxt = {1'b0, lfsr[15:1]} ^ LFSR_TAPS;
        end
    end

    // Lowest-index free slot takes the write; lowest-index ready slot is popped.
    always_comb begin
        slot_ready  = '0;
        free_found  = 1'b0;
        ready_found = 1'b0;
        wr_idx      = '0;
        rd_idx      = '0;
        for (int i = 0; i < NUM_TRANSACTIONS; i++) begin
            slot_ready[i] = slot_valid[i] && (slot_lat[i] == '0);
            if (!free_found && !slot_valid[i]) begin
                free_found = 1'b1;
                wr_idx     = IDX_W'(i);
            end
            if (!ready_found && slot_ready[i]) begin
                ready_found = 1'b1;
                rd_idx      = IDX_W'(i);
            end
        end
    end

    // full is the registered pre-edge flag, so a pop cannot make room for a same-cycle write.
    assign wr_accept = valid_in && !full;
    assign rd_accept = read_en && ready_found;
    assign load_lat  = LAT_W'(MIN_LATENCY) + LAT_W'(lfsr[LAT_RANGE_BITS-1:0]);
    assign count_nxt = count + COUNT_WIDTH'(wr_accept) - COUNT_WIDTH'(rd_accept);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= '0;
            lfsr       <= LFSR_SEED;
            count      <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            valid_out  <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            meta_out   <= '0;
            data_out   <= '0;
            for (int i = 0; i < NUM_TRANSACTIONS; i++) begin
                slot_lat[i] <= '0;
            end
        end else begin
            lfsr      <= lfsr_nxt;
            overflow  <= valid_in && full;
            underflow <= read_en && empty;
            valid_out <= rd_accept;
            if (rd_accept) begin
                meta_out <= slot_meta[rd_idx];
                data_out <= slot_data[rd_idx];
            end
            count <= count_nxt;
            full  <= (count_nxt == COUNT_WIDTH'(NUM_TRANSACTIONS));
            empty <= (count_nxt == '0);
            for (int i = 0; i < NUM_TRANSACTIONS; i++) begin
                if (wr_accept && (wr_idx == IDX_W'(i))) begin
                    slot_valid[i] <= 1'b1;
                    slot_lat[i]   <= load_lat;
                end else begin
                    if (rd_accept && (rd_idx == IDX_W'(i))) begin
                        slot_valid[i] <= 1'b0;
                    end
                    if (slot_valid[i] && (slot_lat[i] != '0)) begin
                        slot_lat[i] <= slot_lat[i] - LAT_W'(1);
                    end
                end
            end
        end
    end

    // Payload storage needs no reset; slot_valid alone decides what is live.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            slot_meta[wr_idx] <= meta_in;
            slot_data[wr_idx] <= data_in;
        end
    end

endmodule

// File: tb/tb_latency_scoreboard.sv
// Bench for latency_scoreboard: directed fill/drain/overflow/underflow/streaming phases and
// a random phase, all checked each cycle against a slot-and-timestamp model.
module tb_latency_scoreboard;

    localparam int N   = 4;
    localparam int HW  = 72;
    localparam int DW  = 72;
    localparam int MIN = 8;
    localparam int R   = 3;
    localparam int CW  = $clog2(N + 1);

    logic          clk;
    logic          rst;
    logic [HW-1:0] meta_in;
    logic [DW-1:0] data_in;
    logic          valid_in;
    logic [HW-1:0] meta_out;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          read_en;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;
    logic [CW-1:0] count;

    latency_scoreboard #(
        .NUM_TRANSACTIONS(N), .HDR_WIDTH(HW), .DATA_WIDTH(DW),
        .MIN_LATENCY(MIN), .LAT_RANGE_BITS(R), .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .meta_in(meta_in), .data_in(data_in), .valid_in(valid_in),
        .meta_out(meta_out), .data_out(data_out), .valid_out(valid_out), .read_en(read_en),
        .empty(empty), .full(full), .overflow(overflow), .underflow(underflow), .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    bit chk_lat  = 1'b0;
    int n_pops   = 0;
    int n_ovf    = 0;

    // Model state: per-slot occupancy plus the first edge index at which each may be popped
    bit            m_valid      [N];
    logic [HW-1:0] m_meta       [N];
    logic [DW-1:0] m_data       [N];
    int            m_ready_edge [N];
    int            m_count;
    logic [15:0]   m_lfsr;
    int            edge_n = 0;
    logic          exp_vo, exp_ovf, exp_udf;
    logic [HW-1:0] exp_meta;
    logic [DW-1:0] exp_data;

    int wr_edge [logic [HW-1:0]];
    int pop_cnt [logic [HW-1:0]];
    int lat_of  [logic [HW-1:0]];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [HW-1:0] mk_meta(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {b, 64'h0123_4567_89AB_CDEF};
    endfunction

    function automatic logic [71:0] rand72();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[71:0];
    endfunction

    initial begin : model
        int  e, rd_slot, wr_slot;
        bit  wr;
        forever begin
            @(posedge clk);
            e = edge_n;
            edge_n++;
            if (rst) begin
                for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
                m_count  = 0;
                m_lfsr   = 16'hACE1;
                exp_vo   = 1'b0;
                exp_ovf  = 1'b0;
                exp_udf  = 1'b0;
                exp_meta = '0;
                exp_data = '0;
            end else begin
                wr      = valid_in && (m_count < N);
                exp_ovf = valid_in && (m_count == N);
                exp_udf = read_en && (m_count == 0);
                rd_slot = -1;
                wr_slot = -1;
                for (int i = 0; i < N; i++) begin
                    if (read_en && rd_slot < 0 && m_valid[i] && e >= m_ready_edge[i]) rd_slot = i;
                    if (wr && wr_slot < 0 && !m_valid[i]) wr_slot = i;
                end
                exp_vo = (rd_slot >= 0);
                if (rd_slot >= 0) begin
                    exp_meta = m_meta[rd_slot];
                    exp_data = m_data[rd_slot];
                    m_valid[rd_slot] = 1'b0;
                    m_count--;
                end
                if (wr) begin
                    m_valid[wr_slot]      = 1'b1;
                    m_meta[wr_slot]       = meta_in;
                    m_data[wr_slot]       = data_in;
                    m_ready_edge[wr_slot] = e + MIN + int'(m_lfsr & 16'((1 << R) - 1)) + 1;
                    m_count++;
                    wr_edge[meta_in] = e;
                end
                m_lfsr = lfsr_step(m_lfsr);
            end
        end
    end

    initial begin : compare
        int el;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("valid_out", valid_out, exp_vo);
                check("meta_out", meta_out, exp_meta);
                check("data_out", data_out, exp_data);
                check("count", count, m_count);
                check("empty", empty, m_count == 0);
                check("full", full, m_count == N);
                check("overflow", overflow, exp_ovf);
                check("underflow", underflow, exp_udf);
                if (overflow) n_ovf++;
                if (valid_out) begin
                    n_pops++;
                    if (pop_cnt.exists(meta_out)) pop_cnt[meta_out]++;
                    else pop_cnt[meta_out] = 1;
                    if (chk_lat && wr_edge.exists(meta_out)) begin
                        el = edge_n - 1 - wr_edge[meta_out];
                        lat_of[meta_out] = el;
                        n_checks++;
                        if (el < MIN + 1 || el > MIN + (1 << R) + N) begin
                            n_errors++;
                            $display("FAIL pop_latency: got %0d cycles, allowed %0d..%0d", el,
                                     MIN + 1, MIN + (1 << R) + N);
                        end
                    end
                end
            end
        end
    end

    initial begin : driver
        int n_wr, got, ovf0, pops0;
        rst = 1'b1; valid_in = 1'b0; read_en = 1'b0; meta_in = '0; data_in = '0;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (39) @(negedge clk);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_valid_out", valid_out, 0);
        check("rst_overflow", overflow, 0);
        check("rst_underflow", underflow, 0);

        // Fill four slots, then a fifth write that must be dropped
        rst = 1'b0;
        chk_lat = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            valid_in = 1'b1;
            meta_in  = mk_meta(i);
            data_in  = rand72();
            @(negedge clk);
            if (i <= 4) check("fill_count", count, i);
        end
        check("fill_full", full, 1);
        check("fill_empty", empty, 0);
        check("ovf_pulse", overflow, 1);
        check("ovf_count", count, 4);
        valid_in = 1'b0;
        read_en  = !empty;
        @(negedge clk);
        check("ovf_single", overflow, 0);

        pops0 = n_pops;
        for (int c = 0; c < 60; c++) begin
            read_en = !empty;
            @(negedge clk);
            if (empty && n_pops - pops0 >= 4) break;
        end
        read_en = 1'b0;
        check("drain_pops", n_pops - pops0, 4);
        check("drain_empty", empty, 1);
        for (int i = 1; i <= 4; i++)
            check("drain_once", pop_cnt.exists(mk_meta(i)) ? pop_cnt[mk_meta(i)] : 0, 1);
        check("ovf_entry_dropped", pop_cnt.exists(mk_meta(5)), 0);
        // First four LFSR draws after reset give extra latency 1,0,0,4
        check("lat_01", lat_of.exists(mk_meta(1)) ? lat_of[mk_meta(1)] : -1, 10);
        check("lat_02", lat_of.exists(mk_meta(2)) ? lat_of[mk_meta(2)] : -1, 10);
        check("lat_03", lat_of.exists(mk_meta(3)) ? lat_of[mk_meta(3)] : -1, 10);
        check("lat_04", lat_of.exists(mk_meta(4)) ? lat_of[mk_meta(4)] : -1, 13);

        read_en = 1'b1;
        @(negedge clk);
        check("udf_pulse", underflow, 1);
        check("udf_valid_out", valid_out, 0);
        read_en = 1'b0;
        @(negedge clk);
        check("udf_single", underflow, 0);

        // Streaming with a writer that honours full and a reader holding read_en=~empty
        n_wr = 0;
        got  = 0;
        ovf0 = n_ovf;
        for (int c = 0; c < 400; c++) begin
            read_en = !empty;
            if (n_wr < 10 && !full) begin
                valid_in = 1'b1;
                meta_in  = mk_meta(16 + n_wr);
                data_in  = rand72();
                n_wr++;
            end else begin
                valid_in = 1'b0;
            end
            @(negedge clk);
            got = 0;
            for (int k = 0; k < 10; k++) if (pop_cnt.exists(mk_meta(16 + k))) got++;
            if (got == 10 && empty) break;
        end
        valid_in = 1'b0;
        read_en  = 1'b0;
        check("stream_all_out", got, 10);
        for (int k = 0; k < 10; k++)
            check("stream_once", pop_cnt.exists(mk_meta(16 + k)) ? pop_cnt[mk_meta(16 + k)] : 0, 1);
        check("stream_no_ovf", n_ovf - ovf0, 0);

        // Reset while transactions are pending
        for (int k = 0; k < 3; k++) begin
            valid_in = 1'b1;
            meta_in  = mk_meta(40 + k);
            data_in  = rand72();
            @(negedge clk);
        end
        valid_in = 1'b0;
        check("pre_rst_count", count, 3);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_count", count, 0);
        check("midrst_empty", empty, 1);
        check("midrst_full", full, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_lat = 1'b0;
        repeat (30) @(negedge clk);
        for (int k = 0; k < 3; k++)
            check("discarded", pop_cnt.exists(mk_meta(40 + k)), 0);

        // Random traffic, including writes while full and reads while empty
        for (int c = 0; c < 600; c++) begin
            rst      = ($urandom_range(0, 199) == 0);
            valid_in = $urandom_range(0, 1) == 1;
            read_en  = $urandom_range(0, 2) != 0;
            meta_in  = rand72();
            data_in  = rand72();
            @(negedge clk);
        end
        rst = 1'b0; valid_in = 1'b0; read_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
